// File: rtl/jtag_host_pkg.sv
// rtl/jtag_host_pkg.sv - shared types and TMS navigation constants for jtag_host
//    state_t          : host sequencer states
//    NAV_*_TMS/LEN    : TMS patterns (LSB first) walking Run-Test/Idle to Shift and back
//    RESET_SEQ_LEN    : TCK cycles in the power-on TAP reset walk
package jtag_host_pkg;

   typedef enum logic [2:0] {
      ST_RESET_SEQ,
      ST_IDLE,
      ST_NAV_IN,
      ST_SHIFT,
      ST_NAV_OUT,
      ST_RESP
   } state_t;

   // Run-Test/Idle -> Select-DR -> Capture-DR -> Shift-DR
   localparam logic [2:0] NAV_DR_TMS  = 3'b001;
   localparam int         NAV_DR_LEN  = 3;
   // Run-Test/Idle -> Select-DR -> Select-IR -> Capture-IR -> Shift-IR
   localparam logic [3:0] NAV_IR_TMS  = 4'b0011;
   localparam int         NAV_IR_LEN  = 4;
   // Exit1 -> Update -> Run-Test/Idle
   localparam logic [1:0] NAV_OUT_TMS = 2'b01;
   localparam int         NAV_OUT_LEN = 2;

   // Five TMS=1 cycles reach Test-Logic-Reset from any state, one TMS=0 lands in Run-Test/Idle
   localparam int RESET_SEQ_LEN  = 6;
   localparam int RESET_TMS_ONES = 5;

   function automatic logic nav_in_tms(input logic ir, input logic [1:0] idx);
      logic [3:0] pat;
      pat = ir ? NAV_IR_TMS : {1'b0, NAV_DR_TMS};
      return pat[idx];
   endfunction

   function automatic logic [2:0] nav_in_len(input logic ir);
      return ir ? 3'(NAV_IR_LEN) : 3'(NAV_DR_LEN);
   endfunction

endpackage

// File: rtl/jtag_host_tckgen.sv
// rtl/jtag_host_tckgen.sv - TCK divider producing the test clock level and edge strobes
//    clk, rstn : system clock, asynchronous active-low reset
//    en        : run the divider; when low TCK parks at 0 and the phase counter clears
//    tck       : TCK level, CLK_DIV clk cycles per half period, starting with a low half
//    fall_stb  : high in the clk cycle whose closing edge drops tck
//    rise_stb  : high in the clk cycle whose closing edge raises tck
module jtag_host_tckgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   output logic tck,
   output logic fall_stb,
   output logic rise_stb
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap     = en && (cnt == CW'(CLK_DIV - 1));
   assign rise_stb = wrap && !tck;
   assign fall_stb = wrap && tck;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
         tck <= 1'b0;
      end else if (!en) begin
         cnt <= '0;
         tck <= 1'b0;
      end else if (wrap) begin
         cnt <= '0;
         tck <= ~tck;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/jtag_host.sv
// rtl/jtag_host.sv - JTAG initiator performing one IR/DR scan per command, Run-Test/Idle to Run-Test/Idle
//    clk, rstn_i                          : clock, asynchronous active-low reset
//    cmd_valid_i/cmd_ready_o              : command handshake
//    cmd_ir_i, cmd_len_i, cmd_data_i      : scan type, bit count (clamped to MAX_LEN), TDI bits LSB first
//    rsp_valid_o/rsp_ready_i, rsp_data_o  : response handshake, captured TDO bits (bit i = i-th shifted)
//    tck_o, tms_o, tdi_o, tdo_i           : JTAG pins
//    trst_no                              : optional TAP reset, present when JTAG_HOST_TRST_EN is defined
module jtag_host
   import jtag_host_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int MAX_LEN = 64,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rstn_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   input  logic               cmd_ir_i,
   input  logic [LEN_W-1:0]   cmd_len_i,
   input  logic [MAX_LEN-1:0] cmd_data_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output logic [MAX_LEN-1:0] rsp_data_o,
   output logic               tck_o,
   output logic               tms_o,
   output logic               tdi_o,
`ifdef JTAG_HOST_TRST_EN
   output logic               trst_no,
`endif
   input  logic               tdo_i
);

   // step must also count the reset walk and the navigation patterns
   localparam int SW = (LEN_W > 3) ? LEN_W : 3;

   state_t             state;
   logic [SW-1:0]      step;
   logic [SW-1:0]      step_inc;
   logic [SW-1:0]      step_inc2;
   logic               ir;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   len_clamped;
   logic [MAX_LEN-1:0] sh;
   logic [MAX_LEN-1:0] cap;
   logic               tck_en;
   logic               fall_stb;
   logic               rise_stb;
   logic               hold;

   assign step_inc    = step + SW'(1);
   assign step_inc2   = step + SW'(2);
   assign len_clamped = (cmd_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len_i;
   assign tck_en      = !hold && (state != ST_IDLE) && (state != ST_RESP);

`ifdef JTAG_HOST_TRST_EN
   localparam int TW = $clog2(2 * CLK_DIV + 1);
   logic [TW-1:0] trst_cnt;

   // TRST stays asserted for one full TCK period after reset release; the TMS walk waits for it
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         trst_cnt <= '0;
         trst_no  <= 1'b0;
      end else if (!trst_no) begin
         if (trst_cnt == TW'(2 * CLK_DIV - 1)) begin
            trst_no <= 1'b1;
         end else begin
            trst_cnt <= trst_cnt + TW'(1);
         end
      end
   end

   assign hold = !trst_no;
`else
   assign hold = 1'b0;
`endif

   jtag_host_tckgen #(
      .CLK_DIV (CLK_DIV)
   ) u_tckgen (
      .clk      (clk),
      .rstn     (rstn_i),
      .en       (tck_en),
      .tck      (tck_o),
      .fall_stb (fall_stb),
      .rise_stb (rise_stb)
   );

   // TMS/TDI for the next TCK cycle are loaded on each falling strobe; the first value of a
   // phase is loaded when the phase is entered so it is valid for that cycle's low half.
   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         state       <= ST_RESET_SEQ;
         step        <= '0;
         ir          <= 1'b0;
         len         <= '0;
         sh          <= '0;
         cap         <= '0;
         tms_o       <= 1'b1;
         tdi_o       <= 1'b0;
         cmd_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
      end else begin
         case (state)
            ST_RESET_SEQ: begin
               if (fall_stb) begin
                  if (step_inc == SW'(RESET_SEQ_LEN)) begin
                     state       <= ST_IDLE;
                     step        <= '0;
                     tms_o       <= 1'b0;
                     cmd_ready_o <= 1'b1;
                  end else begin
                     step  <= step_inc;
                     tms_o <= (step_inc < SW'(RESET_TMS_ONES));
                  end
               end
            end

            ST_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  cmd_ready_o <= 1'b0;
                  ir          <= cmd_ir_i;
                  len         <= len_clamped;
                  sh          <= cmd_data_i;
                  cap         <= '0;
                  rsp_data_o  <= '0;
                  step        <= '0;
                  if (len_clamped == '0) begin
                     state       <= ST_RESP;
                     rsp_valid_o <= 1'b1;
                  end else begin
                     state <= ST_NAV_IN;
                     tms_o <= nav_in_tms(cmd_ir_i, 2'd0);
                     tdi_o <= 1'b0;
                  end
               end
            end

            ST_NAV_IN: begin
               if (fall_stb) begin
                  if (step_inc == SW'(nav_in_len(ir))) begin
                     state <= ST_SHIFT;
                     step  <= '0;
                     tms_o <= (len == LEN_W'(1));
                     tdi_o <= sh[0];
                     sh    <= sh >> 1;
                  end else begin
                     step  <= step_inc;
                     tms_o <= nav_in_tms(ir, step_inc[1:0]);
                  end
               end
            end

            ST_SHIFT: begin
               // TDO enters at the top; after len bits the capture sits in the upper len bits
               if (rise_stb) begin
                  cap <= {tdo_i, cap[MAX_LEN-1:1]};
               end
               if (fall_stb) begin
                  if (step_inc == SW'(len)) begin
                     state      <= ST_NAV_OUT;
                     step       <= '0;
                     tms_o      <= NAV_OUT_TMS[0];
                     tdi_o      <= 1'b0;
                     rsp_data_o <= cap >> (LEN_W'(MAX_LEN) - len);
                  end else begin
                     step  <= step_inc;
                     tms_o <= (step_inc2 == SW'(len));
                     tdi_o <= sh[0];
                     sh    <= sh >> 1;
                  end
               end
            end

            ST_NAV_OUT: begin
               if (fall_stb) begin
                  if (step_inc == SW'(NAV_OUT_LEN)) begin
                     state       <= ST_RESP;
                     step        <= '0;
                     tms_o       <= 1'b0;
                     rsp_valid_o <= 1'b1;
                  end else begin
                     step  <= step_inc;
                     tms_o <= NAV_OUT_TMS[1];
                  end
               end
            end

            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  cmd_ready_o <= 1'b1;
                  state       <= ST_IDLE;
               end
            end

            default: begin
               state <= ST_RESET_SEQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_host.sv
// tb/tb_jtag_host.sv - self-checking bench for jtag_host against a behavioural 5-bit IR / 32-bit DR TAP
module tb_jtag_host;

   localparam int CLK_DIV = 2;
   localparam int MAX_LEN = 64;
   localparam int LEN_W   = 7;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               cmd_valid = 1'b0;
   logic               cmd_ready;
   logic               cmd_ir = 1'b0;
   logic [LEN_W-1:0]   cmd_len = '0;
   logic [MAX_LEN-1:0] cmd_data = '0;
   logic               rsp_valid;
   logic               rsp_ready = 1'b0;
   logic [MAX_LEN-1:0] rsp_data;
   logic               tck, tms, tdi;
   logic               tdo = 1'b0;

   always #5 clk = ~clk;

   jtag_host #(
      .CLK_DIV (CLK_DIV),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) dut (
      .clk         (clk),
      .rstn_i      (rstn),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_ir_i    (cmd_ir),
      .cmd_len_i   (cmd_len),
      .cmd_data_i  (cmd_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .tck_o       (tck),
      .tms_o       (tms),
      .tdi_o       (tdi),
      .tdo_i       (tdo)
   );

   // ---------------- behavioural TAP ----------------
   typedef enum logic [3:0] {
      T_TLR, T_RTI, T_SEL_DR, T_CAP_DR, T_SH_DR, T_EX1_DR, T_PA_DR, T_EX2_DR, T_UPD_DR,
      T_SEL_IR, T_CAP_IR, T_SH_IR, T_EX1_IR, T_PA_IR, T_EX2_IR, T_UPD_IR
   } tap_t;

   function automatic tap_t tap_next(input tap_t s, input logic t);
      case (s)
         T_TLR:    return t ? T_TLR    : T_RTI;
         T_RTI:    return t ? T_SEL_DR : T_RTI;
         T_SEL_DR: return t ? T_SEL_IR : T_CAP_DR;
         T_CAP_DR: return t ? T_EX1_DR : T_SH_DR;
         T_SH_DR:  return t ? T_EX1_DR : T_SH_DR;
         T_EX1_DR: return t ? T_UPD_DR : T_PA_DR;
         T_PA_DR:  return t ? T_EX2_DR : T_PA_DR;
         T_EX2_DR: return t ? T_UPD_DR : T_SH_DR;
         T_UPD_DR: return t ? T_SEL_DR : T_RTI;
         T_SEL_IR: return t ? T_TLR    : T_CAP_IR;
         T_CAP_IR: return t ? T_EX1_IR : T_SH_IR;
         T_SH_IR:  return t ? T_EX1_IR : T_SH_IR;
         T_EX1_IR: return t ? T_UPD_IR : T_PA_IR;
         T_PA_IR:  return t ? T_EX2_IR : T_PA_IR;
         T_EX2_IR: return t ? T_UPD_IR : T_SH_IR;
         default:  return t ? T_SEL_DR : T_RTI;
      endcase
   endfunction

   tap_t        tap_st = T_SH_DR;
   logic [31:0] dr = '0, dr_sr = '0, dr_load = '0;
   logic [4:0]  ir = '0, ir_sr = '0;
   int          load_seq = 0, load_seen = 0;
   int          rises = 0;
   logic        tms_log[$];

   always @(posedge tck) begin
      case (tap_st)
         T_TLR:    ir <= 5'h01;
         T_CAP_DR: begin
            dr_sr     <= (load_seq != load_seen) ? dr_load : dr;
            load_seen <= load_seq;
         end
         T_SH_DR:  dr_sr <= {tdi, dr_sr[31:1]};
         T_UPD_DR: dr <= dr_sr;
         T_CAP_IR: ir_sr <= 5'b00001;
         T_SH_IR:  ir_sr <= {tdi, ir_sr[4:1]};
         T_UPD_IR: ir <= ir_sr;
         default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
      tms_log.push_back(tms);
      rises <= rises + 1;
   end

   always @(negedge tck) begin
      tdo <= (tap_st == T_SH_DR) ? dr_sr[0] : (tap_st == T_SH_IR) ? ir_sr[0] : 1'b0;
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, " reset pins/handshake"}, 64'({tck, tms, tdi, cmd_ready, rsp_valid}), 64'(5'b01000));
      check({tag, " reset rsp_data"}, rsp_data, 64'h0);
   endtask

   // Called just after rstn rises between edges; edge 1 is the next posedge.
   // With CLK_DIV=2 the walk spans edges 1..24 and cmd_ready is seen after edge 24
   // (the 25th cycle counting the first cycle after release as cycle 1).
   task automatic reset_seq_check(input string tag);
      int       start, r0, ready_at, valid_seen;
      logic [5:0] pat;
      start = tms_log.size();
      r0 = rises;
      ready_at = -1;
      valid_seen = 0;
      for (int k = 1; k <= 60 && ready_at < 0; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) valid_seen++;
         if (cmd_ready) ready_at = k;
      end
      check({tag, " cmd_ready edge"}, 64'(ready_at), 64'(24));
      check({tag, " tck rises"}, 64'(rises - r0), 64'(6));
      pat = '0;
      for (int i = 0; i < 6 && start + i < tms_log.size(); i++) pat[i] = tms_log[start + i];
      check({tag, " tms pattern"}, 64'(pat), 64'(6'b011111));
      check({tag, " tap in rti"}, 64'(tap_st == T_RTI), 64'(1));
      check({tag, " no response"}, 64'(valid_seen), 64'(0));
   endtask

   typedef struct {
      logic             ir;
      logic [LEN_W-1:0] len;
      logic [63:0]      data;
      logic [31:0]      pre;
      logic [63:0]      exp_rsp;
      int               exp_rises;
      int               exp_lat;
      logic [31:0]      exp_reg;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input int idx, input vec_t v);
      int          lat, r0, hold_n;
      bit          hold_ok;
      logic [31:0] reg_now;
      if (!v.ir && v.len != 0) begin
         dr_load = v.pre;
         load_seq++;
      end
      @(negedge clk);
      cmd_ir    = v.ir;
      cmd_len   = v.len;
      cmd_data  = v.data;
      cmd_valid = 1'b1;
      for (int k = 0; k < 100 && !cmd_ready; k++) @(negedge clk);
      check($sformatf("v%0d cmd_ready", idx), 64'(cmd_ready), 64'(1));
      @(posedge clk);
      r0 = rises;
      #1 cmd_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 1000) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
      check($sformatf("v%0d rsp_data", idx), rsp_data, v.exp_rsp);
      check($sformatf("v%0d tck rises", idx), 64'(rises - r0), 64'(v.exp_rises));
      check($sformatf("v%0d tap in rti", idx), 64'(tap_st == T_RTI), 64'(1));
      reg_now = v.ir ? {27'b0, ir} : dr;
      check($sformatf("v%0d tap register", idx), 64'(reg_now), 64'(v.exp_reg));
      hold_n = (v.len == 0) ? 10 : 2;
      hold_ok = 1'b1;
      repeat (hold_n) begin
         @(posedge clk); #1;
         if (!(rsp_valid === 1'b1 && rsp_data === v.exp_rsp && cmd_ready === 1'b0 && tck === 1'b0))
            hold_ok = 1'b0;
      end
      check($sformatf("v%0d held response", idx), 64'(hold_ok), 64'(1));
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check($sformatf("v%0d ready after rsp", idx), 64'({cmd_ready, rsp_valid}), 64'(2'b10));
   endtask

   initial begin
      int r0, k;
      //          ir    len      data                    pre           exp_rsp                 N   lat  exp_reg
      vecs[0] = '{1'b1, 7'd5,   64'h11,                 32'h0,        64'h01,                 11, 44,  32'h11};
      vecs[1] = '{1'b0, 7'd32,  64'hDEADBEEF,           32'h12345678, 64'h12345678,           37, 148, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 7'd0,   64'hFFFF,               32'h0,        64'h0,                  0,  0,   32'hDEADBEEF};
      vecs[3] = '{1'b0, 7'd8,   64'hA5,                 32'h12345678, 64'h78,                 13, 52,  32'hA5123456};
      vecs[4] = '{1'b0, 7'd1,   64'h1,                  32'hCAFEBABE, 64'h0,                  6,  24,  32'hE57F5D5F};
      vecs[5] = '{1'b1, 7'd3,   64'h6,                  32'h0,        64'h1,                  9,  36,  32'h18};
      vecs[6] = '{1'b0, 7'd64,  64'h0123456789ABCDEF,   32'h12345678, 64'h89ABCDEF12345678,   69, 276, 32'h01234567};
      vecs[7] = '{1'b0, 7'd100, 64'h0123456789ABCDEF,   32'hFFFFFFFF, 64'h89ABCDEFFFFFFFFF,   69, 276, 32'h01234567};

      repeat (3) @(posedge clk);
      #1 check_reset_outs("por");
      @(negedge clk);
      rstn = 1'b1;
      reset_seq_check("por");

      for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

      // reset pulsed in the middle of a 32-bit DR shift
      dr_load = 32'h0F0F0F0F;
      load_seq++;
      @(negedge clk);
      cmd_ir = 1'b0; cmd_len = 7'd32; cmd_data = 64'h55AA55AA; cmd_valid = 1'b1;
      @(posedge clk);
      r0 = rises;
      #1 cmd_valid = 1'b0;
      k = 0;
      while (!(tap_st == T_SH_DR && rises - r0 >= 10) && k < 1000) begin
         @(posedge clk); #1;
         k++;
      end
      check("midreset reached shift", 64'(tap_st == T_SH_DR), 64'(1));
      #2 rstn = 1'b0;
      #1 check_reset_outs("midreset");
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      reset_seq_check("midreset");

      run_vec(8, vecs[1]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jtag_host.md
# jtag_host

Clock-domain JTAG initiator that drives the TCK/TMS/TDI side of a JTAG link and samples TDO, walking the IEEE 1149.1 TAP state machine on behalf of a simple command/response interface. It is the host end of the debug-transport link: its pins connect to the `jtag_tap`/`debug_transfer_module` chain, either in a loopback SoC bench or as an on-chip debug initiator. One command performs one complete IR or DR scan, Run-Test/Idle to Run-Test/Idle, and returns the captured TDO bits.

## Interface
- `CLK_DIV`, default 4: clk cycles per TCK half-period; legal range ≥1.
- `MAX_LEN`, default 64: maximum scan length in bits; 41 covers a RISC-V DMI scan.
- `LEN_W`, default `$clog2(MAX_LEN+1)`: width of the length field.
- `clk` input 1: the single clock.
- `rstn_i` input 1: reset, asynchronous and active-low.
- `cmd_valid_i` input 1: a command is offered.
- `cmd_ready_o` output 1: the host accepts a command this cycle.
- `cmd_ir_i` input 1: 1 selects an IR scan; 0 selects a DR scan.
- `cmd_len_i` input LEN_W: number of bits to shift, 0..MAX_LEN.
- `cmd_data_i` input MAX_LEN: TDI bits, shifted LSB first.
- `rsp_valid_o` output 1: the response is valid.
- `rsp_ready_i` input 1: the consumer accepts the response.
- `rsp_data_o` output MAX_LEN: captured TDO bits; bit i is the i-th shifted bit; bits ≥ len are 0.
- `tck_o` output 1: JTAG test clock.
- `tms_o` output 1: JTAG test mode select.
- `tdi_o` output 1: JTAG test data in.
- `tdo_i` input 1: JTAG test data out.

## Operation
- Reset values of the outputs:
  - `tck_o`=0, `tms_o`=1, `tdi_o`=0.
  - `cmd_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0.
- **States:** RESET_SEQ → IDLE → NAV_IN → SHIFT → NAV_OUT → RESP → IDLE.
- **RESET_SEQ**, entered after reset deassertion:
  - 5 TCK cycles with TMS=1, then 1 TCK cycle with TMS=0.
  - The TAP then sits in Run-Test/Idle.
- **IDLE:**
  - `cmd_ready_o`=1.
  - A handshake (`cmd_valid_i`&&`cmd_ready_o`) latches the command fields.
- **NAV_IN** TMS sequence:
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0.
- **SHIFT:**
  - `len` TCK cycles; `tdi_o` carries data bit i.
  - TMS=0 for all bits except the last, which has TMS=1 (to Exit1).
  - TDO is sampled on each SHIFT rising edge into rsp bit i.
- **NAV_OUT:** TMS 1,0 (Update, Run-Test/Idle).
- **RESP:**
  - `rsp_valid_o`=1; `rsp_data_o` is held stable until `rsp_ready_i`.
  - `cmd_ready_o` stays 0 throughout.
- **len=0:**
  - No TCK activity occurs.
  - RESP is entered the cycle after acceptance, with data 0.
- **len>MAX_LEN:** clamped to MAX_LEN.
- **Reset mid-scan:**
  - All outputs return to their reset values immediately.
  - The in-flight command is dropped with no response.
  - RESET_SEQ reruns.
- A response and a new command are never concurrent; commands are strictly serialized.

## Timing
- A TCK cycle is a low half of CLK_DIV clk cycles followed by a high half of CLK_DIV clk cycles.
- TMS/TDI change only on the clk edge that makes `tck_o` fall (or on the first low-half cycle).
- TDO is sampled on the clk edge that makes `tck_o` rise.
- TCK cycles per command:
  - DR scan: N = len+5.
  - IR scan: N = len+6.
- `rsp_valid_o` rises exactly N·2·CLK_DIV clk cycles after the accepting edge.
- `tck_o` is 0 in IDLE and RESP.
- `cmd_ready_o` reasserts the cycle after the response handshake.
- RESET_SEQ lasts 6·2·CLK_DIV cycles; `cmd_ready_o` first rises on the cycle after it completes.

## Configuration
- `JTAG_HOST_TRST_EN` defined:
  - Adds output `trst_no`, driven 0 while `rstn_i` is low and for 2·CLK_DIV cycles after release.
  - RESET_SEQ then starts after that window.
- `JTAG_HOST_TRST_EN` undefined:
  - No `trst_no` port.
  - The TAP is reset by the TMS sequence only.

## Structure
- `jtag_host_pkg` holds:
  - the state enum;
  - NAV_IN/NAV_OUT TMS pattern constants and lengths (DR: 3'b001 length 3; IR: 4'b0011 length 4, LSB first; out: 2'b01 length 2);
  - the RESET_SEQ length constant.
- Sub-module `jtag_host_tckgen`:
  - A CLK_DIV counter producing the `tck_o` level plus single-cycle `fall_stb`/`rise_stb` strobes.
  - Enabled only outside IDLE/RESP.

## Test plan
- Reset release with CLK_DIV=2 → 6 TCK cycles with TMS 1,1,1,1,1,0 → `cmd_ready_o` rises at cycle 25.
- IR scan, len=5, data 5'h11, bench TAP captures IR 5'b00001:
  - 11 TCK cycles; `rsp_data_o`=0x01.
  - The bench TAP's IR is 0x11 afterwards.
- DR scan, len=32, data 0xDEADBEEF, through a bench 32-bit DR preloaded with 0x12345678:
  - `rsp_data_o`=0x12345678.
  - The DR holds 0xDEADBEEF afterwards.
  - `rsp_valid_o` rises at 37·2·CLK_DIV cycles after acceptance.
- DR scan, len=41, against the SoC `jtag_tap`/DTM with IR=DMI, dmi write op → the DTM issues a DM write; the next scan's returned op field is 0 (success).
- len=0 → no TCK edges; `rsp_valid_o` rises the next cycle with data 0.
  - Holding `rsp_ready_i`=0 for 10 cycles keeps `rsp_valid_o` and its data stable and `cmd_ready_o`=0.
- `rstn_i` pulsed low mid-SHIFT:
  - Outputs take their reset values in the same cycle.
  - No response is produced.
  - The RESET_SEQ TMS pattern repeats.
